// File: rtl/escalonador_writeback.sv
// rtl/escalonador_writeback.sv - register-file write-back scheduler
// Loads win the single write port; ALU results wait in a small FIFO and are forced through after STARVE_MAX losses.
module escalonador_writeback #(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Alu_Valid,
   input  logic [REG_W-1:0]  Alu_Rd,
   input  logic [DATA_W-1:0] ResultadoF_ALU,
   output logic              Alu_Ready,
   input  logic              Mem_Valid,
   input  logic [REG_W-1:0]  Mem_Rd,
   input  logic [DATA_W-1:0] Exit_DataMem,
   output logic              Mem_Ready,
   output logic              RegWrite,
   output logic [REG_W-1:0]  Write_Register,
   output logic [DATA_W-1:0] Write_Data,
   output logic              MemtoReg
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] L_DEPTH   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);
   localparam logic [STV_W-1:0] L_STV_ONE = STV_W'(1);
   localparam logic [STV_W-1:0] L_STV_MAX = STV_W'(STARVE_MAX);
   localparam logic [REG_W-1:0] L_R0      = '0;

   typedef enum logic {NORMAL, FORCE_ALU} state_t;
   typedef enum logic [1:0] {G_NONE, G_MEM, G_ALU} grant_t;

   state_t              r_state, w_state_next;
   grant_t              w_grant;
   logic [REG_W-1:0]    r_fifo_rd   [DEPTH];
   logic [DATA_W-1:0]   r_fifo_data [DEPTH];
   logic [PTR_W-1:0]    r_wptr, r_rptr;
   logic [CNT_W-1:0]    r_count;
   logic [STV_W-1:0]    r_starv, w_starv_next;
   logic                w_push, w_pop, w_has_entry;
   logic [REG_W-1:0]    w_head_rd;
   logic [DATA_W-1:0]   w_head_data;

   // Readiness uses start-of-cycle count: a full FIFO never accepts, even while popping.
   assign w_has_entry = (r_count != '0);
   assign Alu_Ready   = (r_count < L_DEPTH) && !reset;
   assign Mem_Ready   = (r_state == NORMAL) && !reset;
   assign w_push      = Alu_Valid && Alu_Ready;
   assign w_pop       = (w_grant == G_ALU);
   assign w_head_rd   = r_fifo_rd[r_rptr];
   assign w_head_data = r_fifo_data[r_rptr];

   always_comb begin
      w_grant      = G_NONE;
      w_state_next = r_state;
      w_starv_next = r_starv;
      case (r_state)
         NORMAL: begin
            if (Mem_Valid)        w_grant = G_MEM;
            else if (w_has_entry) w_grant = G_ALU;
            if (w_grant == G_ALU || !w_has_entry) w_starv_next = '0;
            else if (w_grant == G_MEM)            w_starv_next = r_starv + L_STV_ONE;
            if (w_starv_next == L_STV_MAX) w_state_next = FORCE_ALU;
         end
         FORCE_ALU: begin
            if (w_has_entry) w_grant = G_ALU;
            w_starv_next = '0;
            w_state_next = NORMAL;
         end
         default: w_state_next = NORMAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= NORMAL;
         r_starv <= '0;
      end else begin
         r_state <= w_state_next;
         r_starv <= w_starv_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_fifo_rd[r_wptr]   <= Alu_Rd;
         r_fifo_data[r_wptr] <= ResultadoF_ALU;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + L_PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + L_PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + L_CNT_ONE;
         else if (w_pop && !w_push) r_count <= r_count - L_CNT_ONE;
      end
   end

   // Writes to register 0 are consumed but never enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         RegWrite       <= 1'b0;
         Write_Register <= '0;
         Write_Data     <= '0;
         MemtoReg       <= 1'b0;
      end else begin
         case (w_grant)
            G_MEM: begin
               RegWrite       <= (Mem_Rd != L_R0);
               Write_Register <= Mem_Rd;
               Write_Data     <= Exit_DataMem;
               MemtoReg       <= 1'b1;
            end
            G_ALU: begin
               RegWrite       <= (w_head_rd != L_R0);
               Write_Register <= w_head_rd;
               Write_Data     <= w_head_data;
               MemtoReg       <= 1'b0;
            end
            default: RegWrite <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/escalonador_writeback.md
# escalonador_writeback

Write-back scheduler for the register-file write port. It arbitrates between ALU results and data-memory load results, which return with variable latency, and grants the single write port to one of them per cycle. It buffers ALU results that lose arbitration in a small FIFO and back-pressures the execute stage when that FIFO fills. It drives the write-back select and register-file write signals as registered outputs.

## Interface
- DATA_W, 32, data width of results and Write_Data
- REG_W, 5, register index width
- DEPTH, 2, ALU pending-FIFO entries (power of two, ≥2)
- STARVE_MAX, 3, consecutive cycles an ALU head may lose before it is forced through
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Alu_Valid  in  1  ALU result offered
- Alu_Rd  in  REG_W  destination register of ALU result
- ResultadoF_ALU  in  DATA_W  ALU result
- Alu_Ready  out  1  FIFO can accept; 0 = stall execute stage
- Mem_Valid  in  1  load data offered
- Mem_Rd  in  REG_W  destination register of load
- Exit_DataMem  in  DATA_W  load data
- Mem_Ready  out  1  load accepted this cycle
- RegWrite  out  1  register-file write enable
- Write_Register  out  REG_W  register-file write index
- Write_Data  out  DATA_W  register-file write data
- MemtoReg  out  1  source of current write: 1 = memory, 0 = ALU

## Operation
- ALU FIFO: DEPTH entries of {Rd, data} with count register. Enqueue on Alu_Valid && Alu_Ready. Alu_Ready = (count < DEPTH) && !reset, based on the count at the start of the cycle. There is no pass-through when full, even when a pop occurs the same cycle.
- States: NORMAL, FORCE_ALU. Starvation counter starv (width to hold STARVE_MAX).
- NORMAL: Mem_Ready = 1 (0 during reset).
  - If Mem_Valid, grant memory.
  - Else, if count > 0, grant the ALU head (pop).
  - Else, grant nothing.
- starv increments when count > 0 and memory is granted. It clears on any ALU pop or when count = 0. When starv reaches STARVE_MAX, the next state is FORCE_ALU.
- FORCE_ALU: lasts exactly one cycle.
  - Mem_Ready = 0.
  - The ALU head is granted and popped.
  - starv clears and the next state is NORMAL.
- Grant to outputs, registered at the next edge:
  - Memory grant: Write_Register = Mem_Rd, Write_Data = Exit_DataMem, MemtoReg = 1.
  - ALU grant: head Rd and data, MemtoReg = 0.
  - No grant: RegWrite = 0, and the other outputs hold their previous values.
- Register 0: an entry with Rd = 0 is still consumed and granted, but RegWrite = 0 for it. Write_Data and Write_Register still update.
- Simultaneous enqueue and pop with 0 < count < DEPTH: count is unchanged and order is preserved.
- FIFO order is strict; an entry is never dropped or duplicated.

## Timing
- Reset state: RegWrite = 0, Write_Register = 0, Write_Data = 0, MemtoReg = 0, count = 0, starv = 0, state NORMAL. Alu_Ready = 0 and Mem_Ready = 0 while reset is high; inputs are ignored.
- Reset asserted mid-operation flushes the FIFO at that edge. Pending ALU results are discarded, and the upstream stage must replay them.
- Memory latency: a load accepted in cycle N has RegWrite, Write_Data and MemtoReg = 1 visible in cycle N+1.
- ALU latency: a result enqueued at the edge ending cycle N is the head in cycle N+1. With no memory traffic it is written in cycle N+2 (2 cycles minimum).
- Worst-case ALU wait with continuous loads: STARVE_MAX memory grants, then a forced ALU write.
- Mem_Valid with Mem_Ready = 0: the memory source must hold Mem_Valid, Mem_Rd and Exit_DataMem stable. The load is accepted the next cycle.
- Throughput: at most one register-file write per cycle.

## Test plan
- Reset: hold reset 2 cycles with Alu_Valid = Mem_Valid = 1 → RegWrite = 0, Write_Data = 0, Alu_Ready = 0, Mem_Ready = 0, and no enqueue.
- ALU only: ALU {Rd = 5, 0x0000_00AA} in cycle 1 → RegWrite = 1, Write_Register = 5, Write_Data = 0xAA, MemtoReg = 0 in cycle 3.
- Priority: ALU {3, 0x11} in cycle 1 and load {7, 0xDEAD_BEEF} in cycle 2:
  - Cycle 3: Rd 7, MemtoReg = 1.
  - Cycle 4: Rd 3, MemtoReg = 0.
- Back-pressure: Mem_Valid held high with 3 back-to-back ALU results → Alu_Ready = 0 when count = 2, and the third result is held until a slot frees.
- Starvation: Mem_Valid high continuously plus one ALU entry → 3 memory writes, then Mem_Ready = 0 for one cycle and an ALU write with MemtoReg = 0, then memory writes resume with Rd and data unchanged.
- Register 0: ALU {0, 0x1234} → the entry is consumed and RegWrite = 0. A reset pulse with count = 2 → count = 0, and the flushed entries are never written.
